// File: rtl/fetch_decode_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_alu_pkg
// Description : Shared constants for the fetch/decode/ALU slice.
//               - width constants
//               - instruction field bit positions
//               - opcode and ALU funct codes
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_decode_alu_pkg;

    // Width constants
    localparam int INSTR_W  = 32;
    localparam int DATA_W   = 32;
    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int JUMP_W   = 26;

    // Field bit positions (LSB of each field)
    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHIFT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;

    // Opcodes of interest to the control unit
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_LUI   = 6'h0F;

    // ALU funct codes
    localparam logic [FUNCT_W-1:0] FN_SADD = 6'h00;
    localparam logic [FUNCT_W-1:0] FN_SSUB = 6'h01;
    localparam logic [FUNCT_W-1:0] FN_UADD = 6'h02;
    localparam logic [FUNCT_W-1:0] FN_USUB = 6'h03;
    localparam logic [FUNCT_W-1:0] FN_AND  = 6'h04;
    localparam logic [FUNCT_W-1:0] FN_OR   = 6'h05;
    localparam logic [FUNCT_W-1:0] FN_SLL  = 6'h06;
    localparam logic [FUNCT_W-1:0] FN_SRL  = 6'h07;
    localparam logic [FUNCT_W-1:0] FN_SLTU = 6'h08;

endpackage : fetch_decode_alu_pkg
`default_nettype wire

// File: rtl/fetch_decode_alu_alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Combinational 32-bit integer ALU.
//   a, b      in   operands
//   funct     in   operation select (FN_* codes)
//   result    out  operation result
//   overflow  out  signed overflow, only meaningful for FN_SADD / FN_SSUB
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import fetch_decode_alu_pkg::*;
#(
    parameter int DATA_SIZE = 32
) (
    input  logic [DATA_SIZE-1:0] a,
    input  logic [DATA_SIZE-1:0] b,
    input  logic [FUNCT_W-1:0]   funct,
    output logic [DATA_SIZE-1:0] result,
    output logic                 overflow
);

    logic [DATA_SIZE-1:0] sum;
    logic [DATA_SIZE-1:0] diff;
    logic [4:0]           shamt;

    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = b[4:0];

    always_comb begin
        result   = sum;
        overflow = 1'b0;
        case (funct)
            FN_SADD: begin
                result   = sum;
                overflow = (a[DATA_SIZE-1] == b[DATA_SIZE-1]) &&
                           (sum[DATA_SIZE-1] != a[DATA_SIZE-1]);
            end
            FN_SSUB: begin
                result   = diff;
                overflow = (a[DATA_SIZE-1] != b[DATA_SIZE-1]) &&
                           (diff[DATA_SIZE-1] != a[DATA_SIZE-1]);
            end
            FN_UADD: result = sum;
            FN_USUB: result = diff;
            FN_AND:  result = a & b;
            FN_OR:   result = a | b;
            FN_SLL:  result = a << shamt;
            FN_SRL:  result = a >> shamt;
            FN_SLTU: result = (a < b) ? {{(DATA_SIZE-1){1'b0}}, 1'b1}
                                      : {DATA_SIZE{1'b0}};
            default: result = sum;
        endcase
    end

endmodule : alu_core
`default_nettype wire

// File: rtl/fetch_decode_alu.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_alu
// Description : Processor front-end slice: instruction memory with
//               registered fetch, combinational field decode, and a
//               registered 32-bit ALU.
//   clk, rst              clock, synchronous active-high reset
//   pc                    fetch word index (MSB set = out of range)
//   imem_we/waddr/wdata   program-load write port
//   instruction           registered fetched word
//   opcode..jump          decoded fields of instruction
//   alu_a, alu_b          ALU operands
//   alu_funct             ALU operation select
//   alu_result            registered ALU result
//   alu_overflow          registered signed-overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_alu
    import fetch_decode_alu_pkg::*;
#(
    parameter int ADDRESS_WIDTH    = 6,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int DATA_SIZE        = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDRESS_WIDTH:0]      pc,
    input  logic                        imem_we,
    input  logic [ADDRESS_WIDTH-1:0]    imem_waddr,
    input  logic [INSTRUCTION_SIZE-1:0] imem_wdata,
    output logic [INSTRUCTION_SIZE-1:0] instruction,
    output logic [OPCODE_W-1:0]         opcode,
    output logic [REG_W-1:0]            rs,
    output logic [REG_W-1:0]            rt,
    output logic [REG_W-1:0]            rd,
    output logic [REG_W-1:0]            shift,
    output logic [FUNCT_W-1:0]          funct,
    output logic [IMM_W-1:0]            imm,
    output logic [JUMP_W-1:0]           jump,
    input  logic [DATA_SIZE-1:0]        alu_a,
    input  logic [DATA_SIZE-1:0]        alu_b,
    input  logic [FUNCT_W-1:0]          alu_funct,
    output logic [DATA_SIZE-1:0]        alu_result,
    output logic                        alu_overflow
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [INSTRUCTION_SIZE-1:0] imem [0:DEPTH-1];
    logic [DATA_SIZE-1:0]        alu_comb_result;
    logic                        alu_comb_overflow;

    // Program-load port; contents survive reset. The fetch below reads the
    // pre-edge contents, so a same-address write/read returns the old word.
    always_ff @(posedge clk) begin
        if (imem_we && !rst) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    // Registered fetch; pc MSB marks an address outside the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            instruction <= '0;
        end else if (pc[ADDRESS_WIDTH]) begin
            instruction <= '0;
        end else begin
            instruction <= imem[pc[ADDRESS_WIDTH-1:0]];
        end
    end

    // Decode: plain slices, fields overlap intentionally.
    assign opcode = instruction[OPCODE_LSB +: OPCODE_W];
    assign rs     = instruction[RS_LSB     +: REG_W];
    assign rt     = instruction[RT_LSB     +: REG_W];
    assign rd     = instruction[RD_LSB     +: REG_W];
    assign shift  = instruction[SHIFT_LSB  +: REG_W];
    assign funct  = instruction[FUNCT_LSB  +: FUNCT_W];
    assign imm    = instruction[0 +: IMM_W];
    assign jump   = instruction[0 +: JUMP_W];

    alu_core #(
        .DATA_SIZE (DATA_SIZE)
    ) u_alu_core (
        .a        (alu_a),
        .b        (alu_b),
        .funct    (alu_funct),
        .result   (alu_comb_result),
        .overflow (alu_comb_overflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result   <= '0;
            alu_overflow <= 1'b0;
        end else begin
            alu_result   <= alu_comb_result;
            alu_overflow <= alu_comb_overflow;
        end
    end

endmodule : fetch_decode_alu
`default_nettype wire

// File: tb/tb_fetch_decode_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_decode_alu
// Description : Directed self-checking bench for fetch_decode_alu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_decode_alu;

    logic        clk;
    logic        rst;
    logic [6:0]  pc;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] instruction;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shift;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] jump;
    logic [31:0] alu_a, alu_b;
    logic [5:0]  alu_funct;
    logic [31:0] alu_result;
    logic        alu_overflow;

    int tests = 0;
    int fails = 0;

    fetch_decode_alu #(
        .ADDRESS_WIDTH    (6),
        .INSTRUCTION_SIZE (32),
        .DATA_SIZE        (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .instruction  (instruction),
        .opcode       (opcode),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .shift        (shift),
        .funct        (funct),
        .imm          (imm),
        .jump         (jump),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_funct    (alu_funct),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: inputs are set on the falling edge, outputs sampled on the next.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic alu_step(input string tag, input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_r, input logic exp_v);
        alu_funct = f;
        alu_a     = a;
        alu_b     = b;
        tick();
        check({tag, "_res"}, alu_result, exp_r);
        check({tag, "_ovf"}, {31'd0, alu_overflow}, {31'd0, exp_v});
    endtask

    initial begin
        rst = 1'b0; pc = '0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        alu_a = '0; alu_b = '0; alu_funct = '0;
        @(negedge clk);

        // Program load
        imem_we = 1'b1;
        imem_waddr = 6'd3; imem_wdata = 32'h0022_1804; tick();
        imem_waddr = 6'd5; imem_wdata = 32'h3C41_FFFF; tick();
        imem_waddr = 6'd2; imem_wdata = 32'h1111_2222; tick();
        imem_waddr = 6'd4; imem_wdata = 32'h1234_5678; tick();

        // Reset for two cycles; a write attempt during reset must be ignored
        rst = 1'b1; pc = 7'd3;
        imem_waddr = 6'd4; imem_wdata = 32'hAAAA_AAAA;
        tick();
        check("rst_instr_c1", instruction, 32'h0);
        imem_we = 1'b0;
        tick();
        check("rst_instr_c2", instruction, 32'h0);
        check("rst_alu_res", alu_result, 32'h0);
        check("rst_alu_ovf", {31'd0, alu_overflow}, 32'h0);

        // First fetch after release
        rst = 1'b0;
        tick();
        check("fetch3_instr", instruction, 32'h0022_1804);
        check("fetch3_opcode", {26'd0, opcode}, 32'd0);
        check("fetch3_rs", {27'd0, rs}, 32'd1);
        check("fetch3_rt", {27'd0, rt}, 32'd2);
        check("fetch3_rd", {27'd0, rd}, 32'd3);
        check("fetch3_shift", {27'd0, shift}, 32'd0);
        check("fetch3_funct", {26'd0, funct}, 32'd4);

        pc = 7'd5;
        tick();
        check("fetch5_opcode", {26'd0, opcode}, 32'h0F);
        check("fetch5_rs", {27'd0, rs}, 32'd2);
        check("fetch5_rt", {27'd0, rt}, 32'd1);
        check("fetch5_imm", {16'd0, imm}, 32'h0000_FFFF);
        check("fetch5_jump", {6'd0, jump}, 32'h0041_FFFF);

        pc = 7'h7F;
        tick();
        check("fetch_oob", instruction, 32'h0);

        pc = 7'd4;
        tick();
        check("we_ignored_in_rst", instruction, 32'h1234_5678);

        // Same-cycle write and read of address 2
        pc = 7'd2; imem_we = 1'b1; imem_waddr = 6'd2; imem_wdata = 32'hDEAD_BEEF;
        tick();
        check("collision_old", instruction, 32'h1111_2222);
        imem_we = 1'b0;
        tick();
        check("collision_new", instruction, 32'hDEAD_BEEF);

        // ALU
        alu_step("sadd_ovf",  6'h00, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b1);
        alu_step("sadd_plain",6'h00, 32'h5,         32'hFFFF_FFFF, 32'h4,         1'b0);
        alu_step("ssub_neg",  6'h01, 32'h5,         32'h7,         32'hFFFF_FFFE, 1'b0);
        alu_step("ssub_ovf",  6'h01, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b1);
        alu_step("uadd_wrap", 6'h02, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0);
        alu_step("usub_wrap", 6'h03, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0);
        alu_step("and",       6'h04, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0);
        alu_step("or",        6'h05, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11, 1'b0);
        alu_step("sll_mask",  6'h06, 32'h1,         32'h23,        32'h8,         1'b0);
        alu_step("srl_31",    6'h07, 32'h8000_0000, 32'd31,        32'h1,         1'b0);
        alu_step("sltu_lt",   6'h08, 32'h3,         32'h9,         32'h1,         1'b0);
        alu_step("sltu_ge",   6'h08, 32'h9,         32'h3,         32'h0,         1'b0);
        alu_step("sltu_uns",  6'h08, 32'h1,         32'h8000_0000, 32'h1,         1'b0);
        alu_step("default",   6'h3F, 32'h2,         32'h3,         32'h5,         1'b0);

        // Reset mid-stream discards the pending result
        alu_funct = 6'h00; alu_a = 32'h7FFF_FFFF; alu_b = 32'h1;
        tick();
        check("pre_rst_ovf", {31'd0, alu_overflow}, 32'h1);
        alu_a = 32'd10; alu_b = 32'd20; rst = 1'b1; pc = 7'd3;
        tick();
        check("midrst_res", alu_result, 32'h0);
        check("midrst_ovf", {31'd0, alu_overflow}, 32'h0);
        check("midrst_instr", instruction, 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_res", alu_result, 32'd30);
        check("post_rst_instr", instruction, 32'h0022_1804);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_fetch_decode_alu
`default_nettype wire

// File: doc/fetch_decode_alu.md
Name: fetch_decode_alu

Overview:
Processor front-end slice combining three functions:
- instruction memory with a registered fetch,
- combinational field decode of the fetched word,
- registered 32-bit integer ALU selected by a 6-bit funct code.

The control unit drives the pc and ALU operands and consumes the decoded fields and the ALU result. Program words are loaded through a write port before execution starts.

Parameters:
- ADDRESS_WIDTH, 6: log2 of instruction memory depth (64 words). The pc is ADDRESS_WIDTH+1 bits wide.
- INSTRUCTION_SIZE, 32: instruction word width.
- DATA_SIZE, 32: ALU operand and result width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- pc  in  ADDRESS_WIDTH+1  fetch address (word index)
- imem_we  in  1  program-load write enable
- imem_waddr  in  ADDRESS_WIDTH  program-load word address
- imem_wdata  in  INSTRUCTION_SIZE  program-load data
- instruction  out  INSTRUCTION_SIZE  registered fetched word
- opcode  out  6  instruction[31:26]
- rs  out  5  instruction[25:21]
- rt  out  5  instruction[20:16]
- rd  out  5  instruction[15:11]
- shift  out  5  instruction[10:6]
- funct  out  6  instruction[5:0]
- imm  out  16  instruction[15:0]
- jump  out  26  instruction[25:0]
- alu_a  in  DATA_SIZE  operand A
- alu_b  in  DATA_SIZE  operand B
- alu_funct  in  6  ALU operation select
- alu_result  out  DATA_SIZE  registered ALU result
- alu_overflow  out  1  registered signed-overflow flag

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset: instruction, alu_result and alu_overflow become 0 on the first rising edge with rst=1. Memory contents are not cleared. imem_we is ignored while rst=1.
- Fetch:
  - instruction <= imem[pc] at each rising edge; latency is 1 cycle.
  - If pc >= 2**ADDRESS_WIDTH (pc MSB set, e.g. 7'h7F), instruction <= 0.
- Write/read collision: a write and a read of the same address in one cycle returns the old word (read-before-write). The new word is visible from the next fetch.
- Decode: purely combinational slices of the registered instruction. imm and jump overlap the other fields by design. No sign extension is done here.
- ALU: alu_result <= f(alu_a, alu_b) at each edge, latency 1 cycle, by alu_funct:
  - 0x00: signed add. Overflow = operand signs equal and result sign differs.
  - 0x01: signed sub. Overflow = operand signs differ and result sign differs from a.
  - 0x02: unsigned add, modulo 2^32.
  - 0x03: unsigned sub, modulo 2^32.
  - 0x04: bitwise AND.
  - 0x05: bitwise OR.
  - 0x06: a << b[4:0] (logical).
  - 0x07: a >> b[4:0] (logical).
  - 0x08: result = (a < b, unsigned) ? 1 : 0.
  - Any other funct: unsigned add.
- alu_overflow is 0 for every op other than 0x00 and 0x01.
- Shift amounts use only b[4:0]. Higher bits of b are ignored.
- Reset mid-operation: a pending result is discarded and outputs read 0 the cycle after the reset edge. Normal operation resumes on the first edge after rst is deasserted.

Decomposition:
- Shared package holds:
  - opcode and ALU funct localparams (FN_SADD … FN_SLTU);
  - field bit-position constants;
  - width constants.
- One sub-module, alu_core: combinational result plus overflow. The top level registers its outputs.
- Memory array, fetch register and decode slices stay in the top level.

Test Plan:
- Load imem[3]=32'h0022_1804, hold rst=1 for 2 cycles, then pc=3 → instruction=0 during reset. The cycle after release: instruction=32'h0022_1804, opcode=0, rs=1, rt=2, rd=3, funct=4.
- Fetch decode check: imem[5]=32'h3C41_FFFF, pc=5 → opcode=0x0F, rs=2, rt=1, imm=16'hFFFF, jump=26'h041FFFF.
- pc=7'h7F → instruction=0 one cycle later.
- Same-cycle write of imem[2]=32'hDEAD_BEEF while pc=2 → the old word is returned. The next cycle returns 32'hDEAD_BEEF.
- ALU arithmetic:
  - funct 0x00, a=32'h7FFF_FFFF, b=1 → result 32'h8000_0000, overflow=1.
  - funct 0x03, a=0, b=1 → 32'hFFFF_FFFF, overflow=0.
  - funct 0x01, a=5, b=7 → 32'hFFFF_FFFE.
- ALU logic, shift and compare:
  - funct 0x06, a=1, b=32'h23 → 8.
  - funct 0x07, a=32'h8000_0000, b=31 → 1.
  - funct 0x08, a=3, b=9 → 1; a=9, b=3 → 0.
  - funct 0x3F, a=2, b=3 → 5.
  - Asserting rst mid-stream zeroes alu_result on the next edge.
